pulse_burst_gen: RTL

Converts a single-cycle trigger pulse into a burst of square-wave periods on one output line, then reports completion with a single-cycle pulse. It is the transmit-side counterpart of the codebase's level-to-pulse edge detection: downstream control logic fires `trigger` (itself typically produced by edge detection) and this block drives the physical transmitter (e.g. an ultrasound emitter) for a programmable number of periods.

---
 rtl/pulse_burst_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pulse_burst_gen.sv
// Burst generator: a trigger pulse starts num_cycles square-wave periods on `out`,
// each HALF_PERIOD clocks high then HALF_PERIOD clocks low, followed by a one-cycle `done`.
module pulse_burst_gen #(
    parameter int HALF_PERIOD = 4,
    parameter int HP_WIDTH    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [7:0] num_cycles,
    input  logic       abort,
    output logic       out,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [HP_WIDTH-1:0] HP_LAST = HP_WIDTH'(HALF_PERIOD - 1);

    state_t              state_q, state_d;
    logic [HP_WIDTH-1:0] half_q, half_d;
    logic [7:0]          cyc_q, cyc_d;
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            half_q  <= '0;
            cyc_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            cyc_q   <= cyc_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // abort outranks everything; in IDLE it simply swallows a same-cycle trigger
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        cyc_d   = cyc_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (abort) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                half_d  = '0;
                cyc_d   = '0;
                out_d   = 1'b0;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        if (num_cycles != 8'd0) begin
                            state_d = ST_HIGH;
                            half_d  = '0;
                            cyc_d   = num_cycles;
                            out_d   = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (half_q == HP_LAST) begin
                        half_d  = '0;
                        state_d = ST_LOW;
                        out_d   = 1'b0;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (half_q == HP_LAST) begin
                        half_d = '0;
                        cyc_d  = cyc_q - 8'd1;
                        if (cyc_q == 8'd1) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_HIGH;
                            out_d   = 1'b1;
                        end
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    half_d  = '0;
                    cyc_d   = '0;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

    // Structural invariants: busy tracks the active states, done is a lone pulse.
    a_busy_state : assert property (@(posedge clock) disable iff (reset)
        busy_q == (state_q != ST_IDLE));
    a_done_single : assert property (@(posedge clock) disable iff (reset)
        done_q |=> !done_q);
    a_done_not_busy : assert property (@(posedge clock) disable iff (reset)
        done_q |-> !busy_q);

endmodule
